// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - 16x16 shift-and-add multiply sequencer driving the shared execute ALU
// Optional early termination when the multiplier runs out of set bits: ALU_MUL_SEQ_EARLY_EXIT_EN
module alu_mul_seq #(
    parameter logic [4:0] OPC_RR  = 5'b11011,
    parameter logic [1:0] FN_ADD  = 2'b00,
    parameter logic [4:0] OPC_SHF = 5'b11010,
    parameter logic [1:0] FN_SLL  = 2'b01,
    parameter logic [1:0] FN_SRL  = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [4:0]  alu_opcode,
    output logic [1:0]  alu_funct,
    output logic [15:0] alu_src1,
    output logic [15:0] alu_src2,
    input  logic [15:0] alu_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] product_q, product_d;
    logic [3:0]  count_q, count_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= 16'd0;
            mplier_q  <= 16'd0;
            acc_q     <= 16'd0;
            product_q <= 16'd0;
            count_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            count_q   <= count_d;
        end
    end

    // Every working state only advances on a grant, so a denied cycle is a pure stall.
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        product_d  = product_q;
        count_d    = count_q;
        alu_req    = 1'b0;
        alu_opcode = 5'd0;
        alu_funct  = 2'd0;
        alu_src1   = 16'd0;
        alu_src2   = 16'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = 16'd0;
                    count_d  = 4'd0;
                    state_d  = op_b[0] ? S_ADD : S_SHL;
                end
            end
            S_ADD: begin
                alu_req    = 1'b1;
                alu_opcode = OPC_RR;
                alu_funct  = FN_ADD;
                alu_src1   = acc_q;
                alu_src2   = mcand_q;
                if (alu_gnt) begin
                    acc_d   = alu_result;
                    state_d = S_SHL;
                end
            end
            S_SHL: begin
                alu_req    = 1'b1;
                alu_opcode = OPC_SHF;
                alu_funct  = FN_SLL;
                alu_src1   = mcand_q;
                alu_src2   = 16'd1;
                if (alu_gnt) begin
                    mcand_d = alu_result;
                    state_d = S_SHR;
                end
            end
            S_SHR: begin
                alu_req    = 1'b1;
                alu_opcode = OPC_SHF;
                alu_funct  = FN_SRL;
                alu_src1   = mplier_q;
                alu_src2   = 16'd1;
                if (alu_gnt) begin
                    mplier_d = alu_result;
                    count_d  = count_q + 4'd1;
                    if (count_q == 4'd15) begin
                        state_d = S_DONE;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
                    end else if (alu_result == 16'd0) begin
                        state_d = S_DONE;
`endif
                    end else if (alu_result[0]) begin
                        state_d = S_ADD;
                    end else begin
                        state_d = S_SHL;
                    end
                end
            end
            S_DONE: begin
                product_d = acc_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle 16x16 unsigned shift-and-add multiply sequencer. It owns no arithmetic of its own.
- Drives the shared combinational ALU's opcode/funct/src1/src2, requests ALU time from the execute-stage arbiter, and captures aluout on granted cycles.
- Sits beside the execute stage. Returns the low 16 bits of the product to the register-writeback path.

Parameters:
- OPC_RR, 5'b11011, ALU opcode for register-register ALU ops.
- FN_ADD, 2'b00, funct for src1+src2.
- OPC_SHF, 5'b11010, ALU opcode for register shift ops.
- FN_SLL, 2'b01, funct for shift-left-logical src1 by src2[3:0].
- FN_SRL, 2'b11, funct for shift-right-logical src1 by src2[3:0].

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request a multiply; accepted only in IDLE.
- op_a  in  16  multiplicand; sampled on accept.
- op_b  in  16  multiplier; sampled on accept.
- busy  out  1  high from the accept edge until the DONE state is left.
- done  out  1  one-cycle pulse; product is valid.
- product  out  16  low 16 bits of op_a*op_b; held until the next accept.
- alu_req  out  1  sequencer needs the ALU this cycle.
- alu_gnt  in  1  arbiter grants the ALU this cycle.
- alu_opcode  out  5  to ALU opcode.
- alu_funct  out  2  to ALU funct.
- alu_src1  out  16  to ALU src1.
- alu_src2  out  16  to ALU src2.
- alu_result  in  16  ALU aluout, same cycle (combinational).

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; mcand, mplier, acc, count, product = 0.
  - busy=0, done=0, alu_req=0; opcode/funct/src1/src2 = 0.
  - Reset mid-operation aborts the multiply with no done pulse.
- States: IDLE, ADD, SHL, SHR, DONE.
- IDLE:
  - On start=1: mcand<=op_a, mplier<=op_b, acc<=0, count<=0.
  - Next state is ADD if op_b[0]=1, else SHL.
- ADD: drive OPC_RR/FN_ADD, src1=acc, src2=mcand. On gnt: acc<=alu_result, go SHL.
- SHL: drive OPC_SHF/FN_SLL, src1=mcand, src2=16'd1. On gnt: mcand<=alu_result, go SHR.
- SHR: drive OPC_SHF/FN_SRL, src1=mplier, src2=16'd1. On gnt: mplier<=alu_result, count<=count+1.
  - If count==15: go DONE.
  - Otherwise: go ADD if alu_result[0]=1, else SHL.
- DONE: product<=acc, done=1 for exactly this cycle, busy=1. Next state IDLE.
- product is registered. It updates on the DONE→IDLE edge and is visible while in IDLE.
- alu_req=1 only in ADD/SHL/SHR. ALU outputs are 0 in IDLE/DONE.
- Grant rules:
  - alu_gnt=0 → hold state; no register changes; ALU outputs stay stable.
  - alu_gnt while alu_req=0 is ignored.
- Latency with gnt always 1: 32+popcount(op_b) working cycles, then 1 DONE cycle. Each gnt=0 cycle in a working state adds one cycle.
- Arithmetic is modulo 2^16; overflow is silently truncated; there is no high half.
- start while busy is ignored (not queued).
- start high in the DONE cycle is ignored; a new start is accepted from IDLE on the following cycle at the earliest.
- op_a/op_b changes after accept have no effect.

Optional Feature:
- Macro: ALU_MUL_SEQ_EARLY_EXIT_EN.
- Defined: in SHR, if alu_result==0 on a granted cycle, go directly to DONE regardless of count.
  - op_b=0 still takes one SHL and one SHR before DONE.
- Undefined: always exactly 16 SHR steps; fixed-iteration behaviour as above.
- Product value is identical in both builds.

Test Plan:
- Reset, then op_a=3, op_b=5, start, gnt=1: product=15.
  - Without early exit: done 35 cycles after the accept edge.
  - With early exit: done after 8 working cycles.
- op_a=16'hFFFF, op_b=16'hFFFF, gnt=1: product=16'h0001 (truncated); 48 working cycles, early exit or not.
- op_a=7, op_b=9, gnt toggling 1/0 every cycle: product=63; every gnt=0 cycle holds state with unchanged ALU outputs; no register update without gnt.
- op_a=1234, op_b=0, gnt=1: product=0.
  - Without early exit: 32 working cycles, opcodes only SLL/SRL.
  - With early exit: 2 working cycles.
- start pulsed again mid-operation with new operands: ignored; first product unchanged.
  - rst_n=0 at cycle 10 of a multiply: busy=0 and product=0 the next cycle; no done pulse.
- Back-to-back: a=2, b=3 then a=4, b=4, with start held high continuously.
  - Done pulses show products 6 and 16.
  - The second multiply is accepted only on the first IDLE cycle after DONE.
